// File: rtl/haz_det_pkg.sv
// Shared pipeline definitions used by the hazard detection unit.
package haz_det_pkg;

  // Register-address width (16-entry register file).
  localparam int ADDR_W = 4;

  // Encoding of the EX-stage memory-read flag: the flag is active-low, so 0 marks a load.
  localparam logic MEMREAD_ACTIVE = 1'b0;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/haz_cmp.sv
// Pure combinational load-use comparator: flags a load in EX whose destination
// register is a source operand of the instruction in DE.
module haz_cmp
  import haz_det_pkg::*;
#(
  parameter int ADDR_W = haz_det_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] ex_write_addr,
  input  logic [ADDR_W-1:0] de_op1_addr,
  input  logic [ADDR_W-1:0] de_op2_addr,
  input  logic              ex_read_bit,
  output logic              hazard
);

  logic addr_match;

  // Full-width compare on both operands; register 0 is treated like any other register.
  always_comb begin
    addr_match = (ex_write_addr == de_op1_addr) || (ex_write_addr == de_op2_addr);
  end

  // Default to stalling so an unknown read flag or destination address falls into the
  // safe branch in simulation; only a known non-load or a known address miss clears it.
  always_comb begin
    hazard = 1'b1;
    if (ex_read_bit == ~MEMREAD_ACTIVE) begin
      hazard = 1'b0;
    end else if (ex_read_bit == MEMREAD_ACTIVE) begin
      if (addr_match) begin
        hazard = 1'b1;
      end else if (!addr_match) begin
        hazard = 1'b0;
      end
    end
  end

endmodule

// File: rtl/haz_det.sv
// Load-use hazard detection unit: combinational stall controls for PC, IF/DE and
// the DE control word, plus a registered hazard flag and saturating stall counter.
module haz_det
  import haz_det_pkg::*;
#(
  parameter int ADDR_W = haz_det_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] EXwriteAddr,
  input  logic [ADDR_W-1:0] DEop1Addr,
  input  logic [ADDR_W-1:0] DEop2Addr,
  input  logic              EXreadbit,
  output logic              fetchbuffenable,
  output logic              zerocontrol,
  output logic              pcenable,
  output logic              hazard_q,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             hazard;
  logic             hazard_d;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  haz_cmp #(
    .ADDR_W(ADDR_W)
  ) u_haz_cmp (
    .ex_write_addr(EXwriteAddr),
    .de_op1_addr  (DEop1Addr),
    .de_op2_addr  (DEop2Addr),
    .ex_read_bit  (EXreadbit),
    .hazard       (hazard)
  );

  // Stall decode: hold PC and IF/DE and inject a bubble while the hazard is present.
  always_comb begin
    fetchbuffenable = ~hazard;
    zerocontrol     = hazard;
    pcenable        = ~hazard;
  end

  // Next-state for the debug status: follow hazard, count stalls without wrapping.
  always_comb begin
    hazard_d    = hazard;
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Debug status registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      hazard_q    <= hazard_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_haz_det.sv
// Directed scoreboard bench for haz_det: combinational stall controls checked right
// after each input change, status registers checked just after each rising edge.
module tb_haz_det;
  import haz_det_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  reg_addr_t        ex_addr;
  reg_addr_t        op1_addr;
  reg_addr_t        op2_addr;
  logic             read_bit;
  logic             fetchbuffenable;
  logic             zerocontrol;
  logic             pcenable;
  logic             hazard_q;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    string            tag;
    bit               is_reg;
    logic [2:0]       stall;
    logic             hq;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               passed = 0;
  logic             m_hazard;
  logic             m_hq;
  logic [CNT_W-1:0] m_cnt;

  always #5 clk = ~clk;

  haz_det #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .EXwriteAddr    (ex_addr),
    .DEop1Addr      (op1_addr),
    .DEop2Addr      (op2_addr),
    .EXreadbit      (read_bit),
    .fetchbuffenable(fetchbuffenable),
    .zerocontrol    (zerocontrol),
    .pcenable       (pcenable),
    .hazard_q       (hazard_q),
    .stall_cnt      (stall_cnt)
  );

  // Reference hazard: unknown load flag or destination means stall.
  function automatic logic modelHazard(input logic r, input reg_addr_t e, input reg_addr_t a,
                                       input reg_addr_t b);
    if ($isunknown(r) || $isunknown(e)) return 1'b1;
    return (r == 1'b0) && ((e == a) || (e == b));
  endfunction

  function automatic logic [2:0] stallWord(input logic h);
    return h ? 3'b010 : 3'b101;
  endfunction

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("[TB] FAIL scoreboard_empty: got 0 entries expected at least 1");
      return;
    end
    e = sb.pop_front();
    if (!e.is_reg) begin
      total++;
      assert ({fetchbuffenable, zerocontrol, pcenable} === e.stall) passed++;
      else $error("[TB] FAIL %s stall: got %b expected %b", e.tag,
                  {fetchbuffenable, zerocontrol, pcenable}, e.stall);
    end else begin
      total++;
      assert (hazard_q === e.hq) passed++;
      else $error("[TB] FAIL %s hazard_q: got %b expected %b", e.tag, hazard_q, e.hq);
      total++;
      assert (stall_cnt === e.cnt) passed++;
      else $error("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.tag, stall_cnt, e.cnt);
    end
  endtask

  task automatic pushStall(input string tag);
    sb.push_back('{tag, 1'b0, stallWord(m_hazard), 1'b0, '0});
  endtask

  task automatic pushRegs(input string tag);
    sb.push_back('{tag, 1'b1, 3'b000, m_hq, m_cnt});
  endtask

  // Drive new inputs away from the rising edge and check the combinational response.
  task automatic applyStimulus(input string tag, input logic r, input reg_addr_t e,
                               input reg_addr_t a, input reg_addr_t b);
    @(negedge clk);
    read_bit = r;
    ex_addr  = e;
    op1_addr = a;
    op2_addr = b;
    #1;
    m_hazard = modelHazard(r, e, a, b);
    pushStall(tag);
    checkOutput();
  endtask

  // Advance one rising edge, update the status model, check the registers.
  task automatic clockEdge(input string tag);
    @(posedge clk);
    m_hq = m_hazard;
    if (m_hazard && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
    #1;
    pushRegs(tag);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    read_bit = 1'b1;
    ex_addr  = 4'd0;
    op1_addr = 4'd0;
    op2_addr = 4'd0;
    m_hq     = 1'b0;
    m_cnt    = '0;
    m_hazard = 1'b0;
    #2;
    pushRegs("reset");
    checkOutput();
    pushStall("reset_comb");
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("no_match", 1'b0, 4'd5, 4'd2, 4'd3);
    clockEdge("no_match_edge");
    applyStimulus("op2_match", 1'b0, 4'd5, 4'd2, 4'd5);
    clockEdge("op2_match_edge");
    applyStimulus("op1_match", 1'b0, 4'd7, 4'd7, 4'd1);
    clockEdge("op1_match_edge");
    applyStimulus("both_match", 1'b0, 4'd9, 4'd9, 4'd9);
    clockEdge("both_match_edge");
    applyStimulus("reg0_match", 1'b0, 4'd0, 4'd0, 4'd4);
    clockEdge("reg0_match_edge");
    applyStimulus("no_load_match", 1'b1, 4'd5, 4'd5, 4'd5);
    clockEdge("no_load_match_edge");
    applyStimulus("no_load_miss", 1'b1, 4'd5, 4'd2, 4'd3);
    clockEdge("no_load_miss_edge");
    applyStimulus("near_miss", 1'b0, 4'hf, 4'he, 4'h7);
    clockEdge("near_miss_edge");
    applyStimulus("unknown_ex", 1'bx, 4'bxxxx, 4'd5, 4'd5);
    clockEdge("unknown_ex_edge");

    // Reset pulse while a hazard is held: status clears, stall outputs stay put.
    applyStimulus("pre_reset_hazard", 1'b0, 4'd3, 4'd3, 4'd0);
    clockEdge("pre_reset_edge");
    #1;
    rst_n = 1'b0;
    #1;
    m_hq  = 1'b0;
    m_cnt = '0;
    pushRegs("reset_pulse");
    checkOutput();
    pushStall("reset_pulse_comb");
    checkOutput();
    #1;
    rst_n = 1'b1;
    clockEdge("release_mid_hazard");

    // Hold the hazard long enough to reach and stay at the saturated count.
    for (int i = 0; i < 20; i++) begin
      clockEdge("saturate");
    end
    total++;
    assert (stall_cnt === {CNT_W{1'b1}}) passed++;
    else $error("[TB] FAIL saturated_final: got %0d expected %0d", stall_cnt, {CNT_W{1'b1}});

    applyStimulus("clear_after_sat", 1'b1, 4'd3, 4'd3, 4'd0);
    clockEdge("clear_after_sat_edge");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
